// File: rtl/sayeh_window_regfile_if.sv
// sayeh_window_regfile_if: operand/result bus of the windowed register file.
//   master : controller/testbench side, drives write/read/base/clear requests
//   slave  : register file side, returns read data, base and clear status
interface sayeh_window_regfile_if #(
  parameter int DATA_W     = 16,
  parameter int WIN_ADDR_W = 2,
  parameter int BASE_W     = 3
);
  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0]     wr_data;
  logic [LANES-1:0]      wr_lane;
  logic [WIN_ADDR_W-1:0] l_addr;
  logic [WIN_ADDR_W-1:0] r_addr;
  logic                  base_ld;
  logic                  base_add;
  logic [BASE_W-1:0]     base_in;
  logic                  clr_req;
  logic [DATA_W-1:0]     l_out;
  logic [DATA_W-1:0]     r_out;
  logic [BASE_W-1:0]     base_out;
  logic                  clr_busy;
  logic                  clr_done;

  modport master (
    output wr_data, wr_lane, l_addr, r_addr, base_ld, base_add, base_in, clr_req,
    input  l_out, r_out, base_out, clr_busy, clr_done
  );
  modport slave (
    input  wr_data, wr_lane, l_addr, r_addr, base_ld, base_add, base_in, clr_req,
    output l_out, r_out, base_out, clr_busy, clr_done
  );
endinterface

// File: rtl/sayeh_window_regfile.sv
// sayeh_wrf_lane: one byte lane of the write merge (enabled lane takes new data).
module sayeh_wrf_lane (
  input  logic       en,
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  output logic [7:0] res
);
  assign res = en ? new_b : old_b;
endmodule

// sayeh_window_regfile: windowed register file, two combinational read ports,
// one byte-lane-masked write port, base (window pointer) register with modulo
// wrap, clear sequencer and optional write-to-read bypass.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of sayeh_window_regfile_if (data, lanes, addresses,
//                base load/add, clear request; read data, base, clear status)
module sayeh_window_regfile #(
  parameter int DATA_W     = 16,
  parameter int REG_COUNT  = 8,
  parameter int WIN_ADDR_W = 2,
  parameter int BYPASS     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sayeh_window_regfile_if.slave bus
);
  localparam int LANES  = DATA_W / 8;
  localparam int BASE_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [BASE_W-1:0] LAST = BASE_W'(REG_COUNT - 1);
  localparam bit BYP = (BYPASS != 0);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t                           state, state_nxt;
  logic [BASE_W-1:0]                idx, idx_nxt, base;
  logic [REG_COUNT-1:0][DATA_W-1:0] regs;
  logic                             run, idle, wr_en;
  logic [WIN_ADDR_W-1:0]            l_a, r_a;
  logic [BASE_W-1:0]                l_phys, r_phys;
  logic [LANES-1:0][7:0]            cur_l, wdat, merged;
  logic [DATA_W-1:0]                l_val, r_val;

  // Reset release is taken on one edge; functional edges start after it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;

  assign idle  = run && (state == S_IDLE);
  assign wr_en = idle && (|bus.wr_lane);

  // Window-relative to physical: carry out of BASE_W is dropped (modulo wrap).
  assign l_a    = bus.l_addr;
  assign r_a    = bus.r_addr;
  assign l_phys = base + BASE_W'(l_a);
  assign r_phys = base + BASE_W'(r_a);

  assign cur_l = regs[l_phys];
  assign wdat  = bus.wr_data;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sayeh_wrf_lane u_lane (
      .en   (bus.wr_lane[g]),
      .old_b(cur_l[g]),
      .new_b(wdat[g]),
      .res  (merged[g])
    );
  end

  // Register array: clear sequencer owns the write port while busy.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                 regs         <= '0;
    else if (state == S_CLEAR)  regs[idx]    <= '0;
    else if (wr_en)             regs[l_phys] <= merged;

  // Base update; same-cycle write above already used the old base.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) base <= '0;
    else if (idle) begin
      if (bus.base_ld)       base <= bus.base_in;
      else if (bus.base_add) base <= base + bus.base_in;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE:
        if (idle && bus.clr_req) begin
          state_nxt = S_CLEAR;
          idx_nxt   = '0;
        end
      S_CLEAR: begin
        idx_nxt = idx + BASE_W'(1);
        if (idx == LAST) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bypass: the write target (and any read aliasing it) sees merged data.
  always_comb begin
    l_val = regs[l_phys];
    r_val = regs[r_phys];
    if (BYP && wr_en) begin
      l_val = merged;
      if (r_phys == l_phys) r_val = merged;
    end
  end

  assign bus.l_out    = l_val;
  assign bus.r_out    = r_val;
  assign bus.base_out = base;
  assign bus.clr_busy = (state != S_IDLE);
  assign bus.clr_done = (state == S_DONE);
endmodule

// File: tb/tb_sayeh_window_regfile.sv
// tb_sayeh_window_regfile: drives one stimulus stream into a BYPASS=0 and a
// BYPASS=1 instance; a behavioural model pushes per-cycle expectations into a
// scoreboard that is popped and compared before each rising edge.
module tb_sayeh_window_regfile;
  localparam int DW = 16, RC = 8, AW = 2, BW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sayeh_window_regfile_if #(.DATA_W(DW), .WIN_ADDR_W(AW), .BASE_W(BW)) b0 ();
  sayeh_window_regfile_if #(.DATA_W(DW), .WIN_ADDR_W(AW), .BASE_W(BW)) b1 ();

  sayeh_window_regfile #(.DATA_W(DW), .REG_COUNT(RC), .WIN_ADDR_W(AW), .BYPASS(0))
    u_nb (.clk(clk), .rst_n(rst_n), .bus(b0));
  sayeh_window_regfile #(.DATA_W(DW), .REG_COUNT(RC), .WIN_ADDR_W(AW), .BYPASS(1))
    u_byp (.clk(clk), .rst_n(rst_n), .bus(b1));

  assign b1.wr_data  = b0.wr_data;
  assign b1.wr_lane  = b0.wr_lane;
  assign b1.l_addr   = b0.l_addr;
  assign b1.r_addr   = b0.r_addr;
  assign b1.base_ld  = b0.base_ld;
  assign b1.base_add = b0.base_add;
  assign b1.base_in  = b0.base_in;
  assign b1.clr_req  = b0.clr_req;

  typedef struct {
    logic [15:0] l0, r0, l1, r1;
    logic [2:0]  base;
    logic        busy, done;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_pass = 0, cyc = 0, n_busy = 0, n_done = 0;

  logic [15:0] m_regs [RC];
  int m_base, m_state, m_idx;
  bit m_run;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int ph(input int a);
    return (m_base + a) % RC;
  endfunction

  function automatic logic [15:0] mrg(input logic [15:0] old, input logic [15:0] d,
                                      input logic [1:0] ln);
    logic [15:0] res;
    res = old;
    if (ln[0]) res[7:0]  = d[7:0];
    if (ln[1]) res[15:8] = d[15:8];
    return res;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < RC; i++) m_regs[i] = '0;
    m_base = 0; m_state = 0; m_idx = 0; m_run = 0;
  endtask

  task automatic set_in(input logic [15:0] d, input logic [1:0] ln, input int la, input int ra,
                        input logic ld, input logic add, input int bin, input logic clr);
    b0.wr_data = d; b0.wr_lane = ln; b0.l_addr = AW'(la); b0.r_addr = AW'(ra);
    b0.base_ld = ld; b0.base_add = add; b0.base_in = BW'(bin); b0.clr_req = clr;
  endtask

  // Push model expectation for this cycle, then pop and compare both DUTs.
  task automatic sample();
    exp_t e, g;
    bit   we;
    int   lp, rp;
    #1;
    lp = ph(b0.l_addr); rp = ph(b0.r_addr);
    we = m_run && (m_state == 0) && (b0.wr_lane != 0);
    e.l0 = m_regs[lp]; e.r0 = m_regs[rp];
    e.l1 = we ? mrg(m_regs[lp], b0.wr_data, b0.wr_lane) : e.l0;
    e.r1 = (we && lp == rp) ? mrg(m_regs[lp], b0.wr_data, b0.wr_lane) : e.r0;
    e.base = m_base[2:0]; e.busy = (m_state != 0); e.done = (m_state == 2);
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    chk($sformatf("l_out nb c%0d", cyc), b0.l_out, g.l0);
    chk($sformatf("r_out nb c%0d", cyc), b0.r_out, g.r0);
    chk($sformatf("l_out byp c%0d", cyc), b1.l_out, g.l1);
    chk($sformatf("r_out byp c%0d", cyc), b1.r_out, g.r1);
    chk($sformatf("base_out c%0d", cyc), b0.base_out, g.base);
    chk($sformatf("clr_busy c%0d", cyc), b0.clr_busy, g.busy);
    chk($sformatf("clr_done c%0d", cyc), b0.clr_done, g.done);
    if (b0.clr_busy) n_busy++;
    if (b0.clr_done) n_done++;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    cyc++;
    if (!m_run) m_run = 1;
    else case (m_state)
      1: begin
        m_regs[m_idx] = '0;
        if (m_idx == RC - 1) m_state = 2;
        m_idx = (m_idx + 1) % RC;
      end
      2: m_state = 0;
      default: begin
        if (b0.wr_lane != 0)
          m_regs[ph(b0.l_addr)] = mrg(m_regs[ph(b0.l_addr)], b0.wr_data, b0.wr_lane);
        if (b0.base_ld)       m_base = b0.base_in;
        else if (b0.base_add) m_base = (m_base + b0.base_in) % RC;
        if (b0.clr_req) begin m_state = 1; m_idx = 0; end
      end
    endcase
    @(negedge clk);
  endtask

  task automatic tick();
    sample();
    clk_edge();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " l nb"}, b0.l_out, 0);    chk({tag, " r nb"}, b0.r_out, 0);
    chk({tag, " l byp"}, b1.l_out, 0);   chk({tag, " r byp"}, b1.r_out, 0);
    chk({tag, " base"}, b0.base_out, 0); chk({tag, " busy"}, b0.clr_busy, 0);
    chk({tag, " done"}, b0.clr_done, 0); chk({tag, " done byp"}, b1.clr_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();                                            // reset release edge

    // Full write, read back next cycle; other registers stay zero.
    set_in(16'hA55A, 2'b11, 1, 1, 0, 0, 0, 0); tick();
    set_in(0, 0, 1, 1, 0, 0, 0, 0); sample();
    chk("a55a nb", b0.r_out, 16'hA55A); chk("a55a byp", b1.r_out, 16'hA55A);
    clk_edge();
    for (int a = 0; a < 4; a++) begin
      if (a == 1) continue;
      set_in(0, 0, 0, a, 0, 0, 0, 0); sample();
      chk($sformatf("zero r%0d", a), b0.r_out, 0);
      clk_edge();
    end

    // Byte-lane masking.
    set_in(16'h1234, 2'b11, 2, 2, 0, 0, 0, 0); tick();
    set_in(16'hFFEE, 2'b01, 2, 2, 0, 0, 0, 0); tick();
    set_in(16'hAB00, 2'b10, 2, 2, 0, 0, 0, 0); sample();
    chk("lane01 nb", b0.r_out, 16'h12EE); chk("lane10 byp", b1.r_out, 16'hABEE);
    clk_edge();
    set_in(0, 0, 2, 2, 0, 0, 0, 0); sample();
    chk("lane10 nb", b0.r_out, 16'hABEE);
    clk_edge();

    // Window wrap and base arithmetic.
    set_in(0, 0, 0, 0, 1, 0, 7, 0); tick();
    set_in(16'hBEEF, 2'b11, 1, 1, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 1, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); sample();
    chk("wrap beef", b0.r_out, 16'hBEEF);
    clk_edge();
    set_in(0, 0, 0, 0, 1, 0, 6, 0); tick();
    set_in(0, 0, 0, 0, 0, 1, 3, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); sample();
    chk("base_add wrap", b0.base_out, 1);
    clk_edge();

    // Same-cycle bypass vs stored view.
    set_in(16'h5555, 2'b11, 2, 2, 0, 0, 0, 0); tick();
    set_in(16'h00FF, 2'b11, 2, 2, 0, 0, 0, 0); sample();
    chk("bypass byp", b1.r_out, 16'h00FF); chk("bypass nb old", b0.r_out, 16'h5555);
    clk_edge();
    set_in(0, 0, 2, 2, 0, 0, 0, 0); sample();
    chk("bypass nb new", b0.r_out, 16'h00FF);
    clk_edge();

    // Fill all registers, then clear with ignored write/base/clr attempts.
    set_in(0, 0, 0, 0, 1, 0, 0, 0); tick();
    for (int i = 0; i < RC; i++) begin
      set_in(16'h1000 + 16'(i) * 16'h0111, 2'b11, i % 4, i % 4, (i == 3), 0, 4, 0);
      tick();
    end
    set_in(0, 0, 1, 2, 0, 0, 0, 1); tick();
    n_busy = 0; n_done = 0;
    for (int k = 0; k < 11; k++) begin
      if (k < 9) set_in(16'hFFFF, 2'b11, k % 4, (k + 1) % 4, 1, 0, 2, 1);
      else       set_in(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    chk("clr busy cycles", n_busy, 9);
    chk("clr done pulses", n_done, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); sample();
    chk("clr base kept", b0.base_out, 4);
    clk_edge();
    for (int i = 0; i < RC; i++) begin
      set_in(0, 0, i % 4, i % 4, (i == 3), 0, 0, 0); sample();
      chk($sformatf("cleared %0d l", i), b0.l_out, 0);
      chk($sformatf("cleared %0d r", i), b1.r_out, 0);
      clk_edge();
    end

    // Reset in the 4th CLEAR cycle.
    set_in(16'h7777, 2'b11, 3, 3, 0, 0, 0, 0); tick();
    set_in(16'h6666, 2'b11, 1, 1, 1, 0, 2, 0); tick();   // old base 0 -> phys1
    set_in(0, 0, 1, 3, 0, 0, 0, 1); tick();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 1, 3, 0, 0, 0, 0); tick();
    end
    set_in(0, 0, 1, 3, 0, 0, 0, 0); sample();
    chk("pre-rst l", b0.l_out, 16'h7777);
    #1 rst_n = 1'b0;
    #1 chk_zero("mid-clr rst");
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 0, 1, 3, 0, 0, 0, 0);
    tick();
    n_busy = 0; n_done = 0;
    for (int k = 0; k < 12; k++) tick();
    chk("post-rst done", n_done, 0);
    chk("post-rst busy", n_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sayeh_window_regfile.md
# sayeh_window_regfile

Parametrised windowed register file for the SAYEH datapath: two combinational read ports and one byte-lane-masked write port. Window-relative addresses resolve through an internal base (window pointer) register with modulo wrap. Adds a runtime clear sequencer and optional write-to-read bypass. Sits between the ALU result bus and the ALU operand inputs, under control of the controller FSM.

## Interface
- DATA_W, 16: register width; must be a multiple of 8; LANES = DATA_W/8.
- REG_COUNT, 8: physical register count; power of 2, >= 2**WIN_ADDR_W; BASE_W = log2(REG_COUNT).
- WIN_ADDR_W, 2: window-relative address width.
- BYPASS, 0: 1 = read ports see same-cycle write data; 0 = read ports see stored data.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_data  in  DATA_W  write data.
- wr_lane  in  LANES  byte write enables; bit i covers wr_data[8i+7:8i].
- l_addr  in  WIN_ADDR_W  left read address; also the write address.
- r_addr  in  WIN_ADDR_W  right read address.
- base_ld  in  1  load base from base_in.
- base_add  in  1  add base_in to base.
- base_in  in  BASE_W  base load/add operand.
- clr_req  in  1  start a clear sequence.
- l_out  out  DATA_W  register at phys(l_addr).
- r_out  out  DATA_W  register at phys(r_addr).
- base_out  out  BASE_W  current base.
- clr_busy  out  1  clear sequence in progress.
- clr_done  out  1  one-cycle pulse on clear completion.

## Operation
- Physical address: phys(a) = (base + a) mod REG_COUNT, computed at BASE_W bits with the carry discarded.
- Reads are combinational and use the current base.
- Write, at posedge, when in IDLE and wr_lane != 0:
  - Target is phys(l_addr) under the current base.
  - Lanes with wr_lane[i]=1 take wr_data; the other lanes keep their value.
- Base update at posedge, when in IDLE:
  - base_ld has priority and sets base to base_in.
  - Otherwise base_add sets base to (base + base_in) mod REG_COUNT.
  - A write in the same cycle uses the old base.
- BYPASS=1: if wr_lane != 0, not busy, and phys(x_addr) == phys(l_addr), then x_out = the stored value with the enabled lanes replaced by wr_data. This is combinational. l_out always matches the write target.
- BYPASS=0: outputs show stored contents only.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: on clr_req=1, go to CLEAR with idx=0.
  - CLEAR: each cycle write all-zero to physical register idx, then idx++. When idx == REG_COUNT-1 is written, go to DONE.
  - DONE: one cycle, then IDLE.
- During CLEAR and DONE:
  - clr_busy=1.
  - wr_lane, base_ld, base_add and clr_req are ignored.
  - Reads return current contents, so partially cleared registers read 0.
- clr_done=1 only in DONE.

## Timing
- Reset (async assert) sets:
  - All REG_COUNT registers to 0, base to 0, state to IDLE, idx to 0.
  - l_out=0, r_out=0, base_out=0, clr_busy=0, clr_done=0.
- Reset deassertion is registered by the next clk edge; the first functional edge follows.
- Reset asserted mid-clear aborts the sequence immediately; everything is zero on exit.
- Write latency: data is visible on the read ports 1 cycle after the edge, or in the same cycle with BYPASS=1.
- Base latency: the new base affects phys() from the cycle after the edge.
- Clear latency from the clr_req sample edge:
  - clr_busy rises after 1 edge.
  - Registers are zeroed over REG_COUNT edges.
  - clr_done pulses for 1 cycle.
  - clr_busy falls with the end of DONE, for REG_COUNT+1 busy cycles in total.
  - A new clr_req is accepted on the first IDLE edge after that.
- Wrap-around: base=REG_COUNT-1 with a=1 gives phys 0. base_add overflow wraps silently.

## Test plan
- Reset, then write 0xA55A at l_addr=1, base=0, all lanes -> next cycle r_addr=1 reads 0xA55A; other registers read 0.
- Register holds 0x1234; wr_lane=01, wr_data=0xFFEE -> 0x12EE. Then wr_lane=10, wr_data=0xAB00 -> 0xABEE.
- base_ld with base_in=7, write 0xBEEF at l_addr=1 -> after base_ld to 0, r_addr=0 reads 0xBEEF. Then base_add with base_in=3 from base=6 -> base_out=1.
- BYPASS=1: write 0x00FF at l_addr=2 with r_addr=2 -> r_out=0x00FF in the same cycle. BYPASS=0 -> r_out shows the old value until the next cycle.
- Fill all 8 registers, pulse clr_req -> clr_busy high 9 cycles. During this, a write attempt with wr_lane=11 and a base_ld are ignored. clr_done pulses once; afterwards all registers read 0 and base is unchanged.
- Assert rst_n=0 during the 4th CLEAR cycle -> all outputs 0 immediately; after release, state is IDLE and clr_done never pulses.
